// File: rtl/alu_ctrl_seq_if.sv
// Handshake and control bundle between the main decoder, the ALU controller
// and the ALU / iterative mul-div datapath.
interface alu_ctrl_seq_if #(
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4
);
    logic               valid_i;
    logic               ready_o;
    logic [ALUOP_W-1:0] ALUOp_i;
    logic [5:0]         funct_i;
    logic               flush_i;
    logic [CTRL_W-1:0]  ALUCtrl_o;
    logic               ctrl_valid_o;
    logic               illegal_o;
    logic [1:0]         md_op_o;
    logic               md_start_o;
    logic               md_step_o;
    logic               md_done_o;
    logic               stall_o;

    modport master (
        output valid_i, ALUOp_i, funct_i, flush_i,
        input  ready_o, ALUCtrl_o, ctrl_valid_o, illegal_o,
        input  md_op_o, md_start_o, md_step_o, md_done_o, stall_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct_i, flush_i,
        output ready_o, ALUCtrl_o, ctrl_valid_o, illegal_o,
        output md_op_o, md_start_o, md_step_o, md_done_o, stall_o
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller: decodes {ALUOp, funct} into an ALU control code
// behind a valid/ready handshake and sequences multi-cycle mul/div ops.
module alu_ctrl_seq #(
    parameter int ALUOP_W   = 3,
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32,
    parameter int ENABLE_MD = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_ctrl_seq_if.slave bus
);
    localparam int   CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic MD_EN = (ENABLE_MD != 0);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [3:0] C_AND   = 4'd0;
    localparam logic [3:0] C_OR    = 4'd1;
    localparam logic [3:0] C_ADD   = 4'd2;
    localparam logic [3:0] C_SUB   = 4'd3;
    localparam logic [3:0] C_SLT   = 4'd4;
    localparam logic [3:0] C_SLTU  = 4'd5;
    localparam logic [3:0] C_BNE   = 4'd6;
    localparam logic [3:0] C_SLL   = 4'd7;
    localparam logic [3:0] C_SLLV  = 4'd8;
    localparam logic [3:0] C_LUI   = 4'd9;
    localparam logic [3:0] C_ORI   = 4'd10;
    localparam logic [3:0] C_MULT  = 4'd11;
    localparam logic [3:0] C_NOP   = 4'd15;

    // Packs {illegal, is_md, md_op[1:0], code[3:0]}; MULT..DIVU map in funct order.
    function automatic logic [7:0] decode(input logic [ALUOP_W-1:0] op, input logic [5:0] f);
        logic       ill;
        logic       md;
        logic [1:0] mop;
        logic [3:0] code;
        ill  = 1'b0;
        md   = 1'b0;
        mop  = 2'b00;
        code = C_NOP;
        case (op)
            ALUOP_W'(0): begin
                case (f)
                    6'h00:   code = C_SLL;
                    6'h04:   code = C_SLLV;
                    6'h20:   code = C_ADD;
                    6'h22:   code = C_SUB;
                    6'h24:   code = C_AND;
                    6'h25:   code = C_OR;
                    6'h2a:   code = C_SLT;
                    6'h2b:   code = C_SLTU;
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (MD_EN) begin
                            md   = 1'b1;
                            mop  = f[1:0];
                            code = C_MULT + {2'b00, f[1:0]};
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            ALUOP_W'(1): code = C_SUB;
            ALUOP_W'(2): code = C_BNE;
            ALUOP_W'(3): code = C_ADD;
            ALUOP_W'(4): code = C_ORI;
            ALUOP_W'(5): code = C_LUI;
            default:     ill  = 1'b1;
        endcase
        return {ill, md, mop, code};
    endfunction

    logic [1:0]        state_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic [CTRL_W-1:0] code_p1;
    logic [1:0]        md_op_p1;
    logic              vld_p1;
    logic              ill_p1;
    logic              start_p1;
    logic              done_p1;

    logic       dec_ill;
    logic       dec_md;
    logic [1:0] dec_op;
    logic [3:0] dec_code;
    logic       ready;
    logic       accept;
    logic       run;

    // Combinational decode of the request currently on the bus.
    always_comb begin
        {dec_ill, dec_md, dec_op, dec_code} = decode(bus.ALUOp_i, bus.funct_i);
    end

    assign ready  = ((state_p1 == IDLE) || (state_p1 == MD_DONE)) && !bus.flush_i && rst_i;
    assign accept = bus.valid_i && ready;
    assign run    = MD_EN && (state_p1 == MD_RUN);

    // Controller FSM, iteration counter and registered result/pulse outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
            code_p1  <= CTRL_W'(C_NOP);
            md_op_p1 <= 2'b00;
            vld_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            start_p1 <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            vld_p1   <= 1'b0;
            ill_p1   <= 1'b0;
            start_p1 <= 1'b0;
            done_p1  <= 1'b0;
            if (bus.flush_i) begin
                // An aborted mul/div op must not leave a stale MD code behind.
                if (state_p1 == MD_RUN) begin
                    code_p1 <= CTRL_W'(C_NOP);
                end
                state_p1 <= IDLE;
            end else begin
                case (state_p1)
                    MD_RUN: begin
                        if (cnt_p1 == '0) begin
                            state_p1 <= MD_DONE;
                            done_p1  <= 1'b1;
                            vld_p1   <= 1'b1;
                        end else begin
                            cnt_p1 <= cnt_p1 - 1'b1;
                        end
                    end
                    default: begin
                        state_p1 <= IDLE;
                        if (accept) begin
                            code_p1 <= CTRL_W'(dec_code);
                            if (dec_md) begin
                                state_p1 <= MD_RUN;
                                cnt_p1   <= CNT_W'(MD_CYCLES - 1);
                                md_op_p1 <= dec_op;
                                start_p1 <= 1'b1;
                            end else begin
                                vld_p1 <= 1'b1;
                                ill_p1 <= dec_ill;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ready_o      = ready;
    assign bus.ALUCtrl_o    = code_p1;
    assign bus.ctrl_valid_o = vld_p1;
    assign bus.illegal_o    = ill_p1;
    assign bus.md_op_o      = MD_EN ? md_op_p1 : 2'b00;
    assign bus.md_start_o   = MD_EN && start_p1;
    assign bus.md_step_o    = run;
    assign bus.md_done_o    = MD_EN && done_p1;
    assign bus.stall_o      = run;
endmodule
